launch_sequencer: RTL and testbench

- Command-level controller that sequences the shared turntable and launcher servo drivers for the main-operation (non-maintenance) launch mode.
- Accepts one aim angle per command, then runs a fixed, timed sequence:
  - rotate the turntable and let it settle
  - drive the launcher to its fire position
  - retract the launcher
  - signal completion
- Sits between the decoded mbed instruction word and the two servo-driver instances, and owns their enable and position inputs while a sequence runs.

---
 rtl/launch_sequencer_pkg.sv | 22 ++
 rtl/launch_sequencer_phase_timer.sv | 30 +++
 rtl/launch_sequencer.sv | 136 +++++++++++++
 tb/tb_launch_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/launch_sequencer_pkg.sv
// Shared state codes, default servo positions and the aim-angle clamp used by
// the main launch path and the maintenance path.
package launch_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AIM     = 3'd1,
    FIRE    = 3'd2,
    RETRACT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [7:0] HOME_ANGLE = 8'd90;
  localparam logic [7:0] FIRE_POS   = 8'd200;
  localparam logic [7:0] REST_POS   = 8'd0;

  function automatic logic [7:0] clamp_angle(input logic [7:0] angle,
                                             input logic [7:0] max_angle);
    return (angle > max_angle) ? max_angle : angle;
  endfunction

endpackage

// File: rtl/launch_sequencer_phase_timer.sv
// Loadable down-counter; expire is high during the last cycle of a loaded period.
// Latency: a load of N gives expire in the Nth cycle after the load edge; no backpressure.
module launch_sequencer_phase_timer #(
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  // Parked at zero once a period ends, so expire cannot re-fire until the next load.
  assign expire = (count == ONE);

endmodule

// File: rtl/launch_sequencer.sv
// Sequences turntable aim, launcher fire and retract for one command at a time.
// Latency: AIM+FIRE+RETRACT cycles from accept to the done pulse; cmd_ready low while busy, no queueing.
module launch_sequencer #(
  parameter int         AIM_CYCLES     = 50000000,
  parameter int         FIRE_CYCLES    = 25000000,
  parameter int         RETRACT_CYCLES = 25000000,
  parameter int         MAX_ANGLE      = 180,
  parameter logic [7:0] HOME_ANGLE     = launch_sequencer_pkg::HOME_ANGLE,
  parameter logic [7:0] FIRE_POS       = launch_sequencer_pkg::FIRE_POS,
  parameter logic [7:0] REST_POS       = launch_sequencer_pkg::REST_POS,
  parameter int         CNT_W          = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_angle,
  output logic       cmd_ready,
  input  logic       abort,
  output logic       turntable_en,
  output logic [7:0] turntable_pos,
  output logic       launcher_en,
  output logic [7:0] launcher_pos,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [7:0] launch_count
);

  import launch_sequencer_pkg::*;

  localparam logic [CNT_W-1:0] AIM_LD     = CNT_W'(AIM_CYCLES);
  localparam logic [CNT_W-1:0] FIRE_LD    = CNT_W'(FIRE_CYCLES);
  localparam logic [CNT_W-1:0] RETRACT_LD = CNT_W'(RETRACT_CYCLES);
  localparam logic [7:0]       MAX_A      = 8'(MAX_ANGLE);

  state_t           state, state_nx;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_expire;
  logic             abort_retract, abort_retract_nx;
  logic             turntable_en_nx, launcher_en_nx, done_nx, aborted_nx;
  logic [7:0]       turntable_pos_nx, launcher_pos_nx, launch_count_nx;

  launch_sequencer_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  assign cmd_ready = (state == IDLE) & ~abort;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      abort_retract <= 1'b0;
      turntable_en  <= 1'b0;
      launcher_en   <= 1'b0;
      turntable_pos <= HOME_ANGLE;
      launcher_pos  <= REST_POS;
      done          <= 1'b0;
      aborted       <= 1'b0;
      launch_count  <= 8'd0;
    end else begin
      state         <= state_nx;
      abort_retract <= abort_retract_nx;
      turntable_en  <= turntable_en_nx;
      launcher_en   <= launcher_en_nx;
      turntable_pos <= turntable_pos_nx;
      launcher_pos  <= launcher_pos_nx;
      done          <= done_nx;
      aborted       <= aborted_nx;
      launch_count  <= launch_count_nx;
    end
  end

  always_comb begin
    state_nx         = state;
    tmr_load         = 1'b0;
    tmr_val          = '0;
    abort_retract_nx = abort_retract;
    aborted_nx       = 1'b0;
    turntable_pos_nx = turntable_pos;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_nx         = AIM;
          tmr_load         = 1'b1;
          tmr_val          = AIM_LD;
          turntable_pos_nx = clamp_angle(cmd_angle, MAX_A);
          abort_retract_nx = 1'b0;
        end
      end
      AIM: begin
        if (abort) begin
          state_nx   = IDLE;
          aborted_nx = 1'b1;
        end else if (tmr_expire) begin
          state_nx = FIRE;
          tmr_load = 1'b1;
          tmr_val  = FIRE_LD;
        end
      end
      FIRE: begin
        // An abort still retracts the launcher, but remembers to skip DONE.
        if (abort || tmr_expire) begin
          state_nx = RETRACT;
          tmr_load = 1'b1;
          tmr_val  = RETRACT_LD;
        end
        if (abort) begin
          aborted_nx       = 1'b1;
          abort_retract_nx = 1'b1;
        end
      end
      RETRACT: begin
        if (tmr_expire) begin
          state_nx         = abort_retract ? IDLE : DONE;
          abort_retract_nx = 1'b0;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    turntable_en_nx = (state_nx == AIM) || (state_nx == FIRE) || (state_nx == RETRACT);
    launcher_en_nx  = (state_nx == FIRE) || (state_nx == RETRACT);
    launcher_pos_nx = (state_nx == FIRE) ? FIRE_POS : REST_POS;
    done_nx         = (state_nx == DONE);
    launch_count_nx = (state_nx == DONE) ? launch_count + 8'd1 : launch_count;
  end

endmodule

// File: tb/tb_launch_sequencer.sv
// Bench for launch_sequencer: timeline-based reference model plus directed literal checks.
module tb_launch_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_angle = 8'd0;
  logic       abort = 1'b0;
  logic       cmd_ready, turntable_en, launcher_en, busy, done, aborted;
  logic [7:0] turntable_pos, launcher_pos, launch_count;

  launch_sequencer #(
    .AIM_CYCLES(4), .FIRE_CYCLES(3), .RETRACT_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_angle(cmd_angle),
    .cmd_ready(cmd_ready), .abort(abort), .turntable_en(turntable_en),
    .turntable_pos(turntable_pos), .launcher_en(launcher_en),
    .launcher_pos(launcher_pos), .busy(busy), .done(done),
    .aborted(aborted), .launch_count(launch_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: the current cycle's phase plus a timeline of phases still to come.
  // Phase labels: 0 idle, 1 aim, 2 fire, 3 retract, 4 done.
  int q[$];
  int m_phase = 0;
  int m_tpos = 90;
  int m_count = 0;
  bit m_aborted = 0;
  bit model_on = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic v, input logic [7:0] a, input logic ab, input logic r);
    if (r) begin
      q.delete();
      m_phase = 0; m_tpos = 90; m_count = 0; m_aborted = 0;
    end else begin
      m_aborted = 0;
      if (m_phase == 0 && v && !ab) begin
        m_tpos = (a > 180) ? 180 : int'(a);
        repeat (4) q.push_back(1);
        repeat (3) q.push_back(2);
        repeat (2) q.push_back(3);
        q.push_back(4);
      end else if (m_phase == 1 && ab) begin
        q.delete();
        m_aborted = 1;
      end else if (m_phase == 2 && ab) begin
        q.delete();
        repeat (2) q.push_back(3);
        m_aborted = 1;
      end
      m_phase = (q.size() > 0) ? q.pop_front() : 0;
      if (m_phase == 4) m_count = (m_count + 1) % 256;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] a, input logic ab, input logic r);
    cmd_valid = v; cmd_angle = a; abort = ab; rst = r;
    @(posedge clk);
    #1;
    model_edge(v, a, ab, r);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'($urandom), 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      chk("busy",          busy,          m_phase != 0);
      chk("cmd_ready",     cmd_ready,     (m_phase == 0) && !abort);
      chk("turntable_en",  turntable_en,  (m_phase >= 1) && (m_phase <= 3));
      chk("launcher_en",   launcher_en,   (m_phase == 2) || (m_phase == 3));
      chk("launcher_pos",  launcher_pos,  (m_phase == 2) ? 200 : 0);
      chk("turntable_pos", turntable_pos, m_tpos);
      chk("done",          done,          m_phase == 4);
      chk("aborted",       aborted,       m_aborted);
      chk("launch_count",  launch_count,  m_count);
    end
  end

  initial begin
    step(1'b0, 8'd0, 1'b0, 1'b1);
    model_on = 1;
    step(1'b0, 8'd0, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk("lit_reset_tpos",  turntable_pos, 90);
    chk("lit_reset_lpos",  launcher_pos, 0);
    chk("lit_reset_ten",   turntable_en, 0);
    chk("lit_reset_len",   launcher_en, 0);
    chk("lit_reset_ready", cmd_ready, 1);
    chk("lit_reset_count", launch_count, 0);

    // Normal launch at 45 degrees.
    step(1'b1, 8'd45, 1'b0, 1'b0);
    chk("lit_aim_tpos", turntable_pos, 45);
    chk("lit_aim_ten",  turntable_en, 1);
    chk("lit_aim_len",  launcher_en, 0);
    idle(3);
    chk("lit_aim4_len", launcher_en, 0);
    idle(1);
    chk("lit_fire_lpos", launcher_pos, 200);
    idle(3);
    chk("lit_retract_lpos", launcher_pos, 0);
    chk("lit_retract_len",  launcher_en, 1);
    idle(2);
    chk("lit_done",       done, 1);
    chk("lit_done_count", launch_count, 1);
    idle(1);
    chk("lit_ready_back", cmd_ready, 1);
    chk("lit_done_gone",  done, 0);

    // Clamp and ignored mid-sequence command.
    step(1'b1, 8'd250, 1'b0, 1'b0);
    chk("lit_clamp", turntable_pos, 180);
    step(1'b1, 8'd10, 1'b0, 1'b0);
    idle(8);
    chk("lit_clamp_done",  done, 1);
    chk("lit_clamp_count", launch_count, 2);
    chk("lit_clamp_hold",  turntable_pos, 180);
    idle(1);

    // Abort in the second AIM cycle.
    step(1'b1, 8'd60, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("lit_abort_aim_pulse", aborted, 1);
    chk("lit_abort_aim_ten",   turntable_en, 0);
    chk("lit_abort_aim_busy",  busy, 0);
    idle(1);
    chk("lit_abort_aim_pulse_end", aborted, 0);
    chk("lit_abort_aim_count",     launch_count, 2);

    // Abort in the first FIRE cycle.
    step(1'b1, 8'd30, 1'b0, 1'b0);
    idle(4);
    chk("lit_fire1_lpos", launcher_pos, 200);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("lit_abort_fire_pulse", aborted, 1);
    chk("lit_abort_fire_lpos",  launcher_pos, 0);
    chk("lit_abort_fire_len",   launcher_en, 1);
    idle(1);
    chk("lit_abort_fire_busy2", busy, 1);
    chk("lit_abort_fire_pulse_end", aborted, 0);
    idle(1);
    chk("lit_abort_fire_idle",  busy, 0);
    chk("lit_abort_fire_done",  done, 0);
    chk("lit_abort_fire_count", launch_count, 2);

    // Reset during FIRE.
    step(1'b1, 8'd100, 1'b0, 1'b0);
    idle(5);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    chk("lit_rst_fire_ten",   turntable_en, 0);
    chk("lit_rst_fire_len",   launcher_en, 0);
    chk("lit_rst_fire_tpos",  turntable_pos, 90);
    chk("lit_rst_fire_lpos",  launcher_pos, 0);
    chk("lit_rst_fire_count", launch_count, 0);
    chk("lit_rst_fire_busy",  busy, 0);

    // cmd_valid with abort in IDLE is refused.
    step(1'b1, 8'd77, 1'b1, 1'b0);
    chk("lit_idle_abort_busy",  busy, 0);
    chk("lit_idle_abort_pulse", aborted, 0);
    chk("lit_idle_abort_tpos",  turntable_pos, 90);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(2) == 0), 8'($urandom),
           ($urandom_range(9) == 0), ($urandom_range(299) == 0));
    end

    // 256 completed launches wrap the counter.
    step(1'b0, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      idle(10);
      if (i == 254) chk("lit_count_255", launch_count, 255);
    end
    chk("lit_count_wrap", launch_count, 0);

    model_on = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
